// File: rtl/conv2d_stride_engine.sv
// rtl/conv2d_stride_engine.sv - strided 2-D convolution, one sequential MAC, valid/ready output stream
// Optional CONV2D_RELU_EN clamps negative results to zero after shift and saturation.
module conv2d_stride_engine #(
  parameter int IMG    = 7,
  parameter int KER    = 3,
  parameter int STRIDE = 1,
  parameter int WIDTH  = 8,
  parameter int SHIFT  = 0,
  localparam int ODIM  = (IMG - KER) / STRIDE + 1,
  localparam int OW    = $clog2(ODIM + 1)
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] img [IMG][IMG],
  input  logic signed [WIDTH-1:0] kernel [KER][KER],
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [OW-1:0]           out_row,
  output logic [OW-1:0]           out_col,
  output logic                    done
);

  localparam int ACC_W = 2 * WIDTH + $clog2(KER * KER);
  localparam int RW    = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int KW    = (KER > 1) ? $clog2(KER) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FIN} state_t;

  state_t                   state, state_nx;
  logic [OW-1:0]            oi, oj;
  logic [KW-1:0]            ki, kj;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]  sat;
  logic [RW-1:0]            r_idx, c_idx;
  logic                     kj_last, ki_last, last_tap, oj_last, last_win;

  assign kj_last  = (kj == KW'(KER - 1));
  assign ki_last  = (ki == KW'(KER - 1));
  assign last_tap = kj_last && ki_last;
  assign oj_last  = (oj == OW'(ODIM - 1));
  assign last_win = oj_last && (oi == OW'(ODIM - 1));

  assign r_idx = RW'(32'(oi) * STRIDE + 32'(ki));
  assign c_idx = RW'(32'(oj) * STRIDE + 32'(kj));
  assign prod  = img[r_idx][c_idx] * kernel[ki][kj];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_MAC;
      S_MAC:   if (last_tap) state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = last_win ? S_FIN : S_MAC;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc <= '0;
      oi  <= '0;
      oj  <= '0;
      ki  <= '0;
      kj  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc <= '0;
          oi  <= '0;
          oj  <= '0;
          ki  <= '0;
          kj  <= '0;
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (kj_last) begin
            kj <= '0;
            ki <= ki_last ? '0 : ki + KW'(1);
          end else begin
            kj <= kj + KW'(1);
          end
        end
        // the last window keeps its coordinates so FIN still reports them
        S_OUT: if (out_ready && !last_win) begin
          acc <= '0;
          ki  <= '0;
          kj  <= '0;
          if (oj_last) begin
            oj <= '0;
            oi <= oi + OW'(1);
          end else begin
            oj <= oj + OW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
`ifdef CONV2D_RELU_EN
    if (sat[WIDTH-1]) sat = '0;
`else
    sat = sat;
`endif
  end

  assign busy      = (state == S_MAC) || (state == S_OUT);
  assign out_valid = (state == S_OUT);
  assign done      = (state == S_FIN);
  assign out_data  = (state == S_OUT) ? sat : '0;
  assign out_row   = oi;
  assign out_col   = oj;

endmodule

// File: tb/tb_conv2d_stride_engine.sv
// tb/tb_conv2d_stride_engine.sv - randomized self-checking bench for conv2d_stride_engine
module tb_conv2d_stride_engine;

  logic clock;
  logic nreset;
  logic start, ready;
  int   use_b;

  logic a_start, a_ready, a_busy, a_valid, a_done;
  logic signed [7:0] a_data;
  logic [1:0] a_row, a_col;
  logic signed [7:0] a_img [4][4];
  logic signed [7:0] a_ker [3][3];

  logic b_start, b_ready, b_busy, b_valid, b_done;
  logic signed [7:0] b_data;
  logic [1:0] b_row, b_col;
  logic signed [7:0] b_img [7][7];
  logic signed [7:0] b_ker [3][3];

  logic s_valid, s_done, s_busy;
  logic signed [7:0] s_data;
  logic [1:0] s_row, s_col;

  int n_assert = 0;
  int n_fail   = 0;
  int m_img [7][7];
  int m_ker [3][3];
  int cur_stride, cur_odim;
  logic signed [7:0] first_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign a_start = start && (use_b == 0);
  assign b_start = start && (use_b != 0);
  assign a_ready = ready;
  assign b_ready = ready;

  always_comb begin
    s_valid = use_b != 0 ? b_valid : a_valid;
    s_done  = use_b != 0 ? b_done  : a_done;
    s_busy  = use_b != 0 ? b_busy  : a_busy;
    s_data  = use_b != 0 ? b_data  : a_data;
    s_row   = use_b != 0 ? b_row   : a_row;
    s_col   = use_b != 0 ? b_col   : a_col;
  end

  conv2d_stride_engine #(.IMG(4), .KER(3), .STRIDE(1), .WIDTH(8), .SHIFT(0)) u_a (
    .clock(clock), .nreset(nreset), .start(a_start), .img(a_img), .kernel(a_ker),
    .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
    .out_row(a_row), .out_col(a_col), .done(a_done)
  );

  conv2d_stride_engine #(.IMG(7), .KER(3), .STRIDE(2), .WIDTH(8), .SHIFT(0)) u_b (
    .clock(clock), .nreset(nreset), .start(b_start), .img(b_img), .kernel(b_ker),
    .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .done(b_done)
  );

  // Reference: direct sum over the window, then clamp to 8-bit signed.
  function automatic int model_pix(int oi, int oj);
    int acc;
    acc = 0;
    for (int ki = 0; ki < 3; ki++)
      for (int kj = 0; kj < 3; kj++)
        acc += m_img[oi*cur_stride+ki][oj*cur_stride+kj] * m_ker[ki][kj];
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
`ifdef CONV2D_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic set_geom(input int b);
    use_b      = b;
    cur_stride = (b != 0) ? 2 : 1;
    cur_odim   = (b != 0) ? 3 : 2;
  endtask

  task automatic load_dut();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        b_img[r][c] = 8'(m_img[r][c]);
        if (r < 4 && c < 4) a_img[r][c] = 8'(m_img[r][c]);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a_ker[r][c] = 8'(m_ker[r][c]);
        b_ker[r][c] = 8'(m_ker[r][c]);
      end
  endtask

  task automatic fill(input int pix, input int w);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) m_img[r][c] = pix;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) m_ker[r][c] = w;
    load_dut();
  endtask

  task automatic run_frame(input int stall_at, input int stall_len, input int spur_at,
                           input int rand_ready, input int exp_first, input int exp_done);
    int cyc, k, stalls, npix, first_seen, expv, got_done;
    logic signed [7:0] e8;
    npix = cur_odim * cur_odim;
    k = 0; stalls = stall_len; first_seen = -1; got_done = 0; cyc = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    while (cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        n_assert++;
        if (s_busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_after_start: got %b expected 1", s_busy);
        end
      end
      if (s_valid === 1'b1) begin
        if (first_seen < 0) first_seen = cyc;
        n_assert++;
        if (k >= npix) begin
          n_fail++; $display("FAIL extra_output: got output %0d expected only %0d", k, npix);
          ready = 1'b1;
        end else begin
          expv = model_pix(k / cur_odim, k % cur_odim);
          e8 = 8'(expv);
          if (s_data !== e8 || s_row !== 2'(k / cur_odim) || s_col !== 2'(k % cur_odim)) begin
            n_fail++;
            $display("FAIL pixel %0d: got %0d at (%0d,%0d) expected %0d at (%0d,%0d)",
                     k, s_data, s_row, s_col, e8, k / cur_odim, k % cur_odim);
          end
          if (k == 0) first_data = s_data;
          if (k == stall_at && stalls > 0) begin
            ready = 1'b0; stalls--;
          end else if (rand_ready != 0 && $urandom_range(0, 2) == 0) begin
            ready = 1'b0;
          end else begin
            ready = 1'b1; k++;
          end
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
      start = (cyc == spur_at);
      if (s_done === 1'b1) begin
        got_done = 1;
        n_assert++;
        if (k != npix || s_valid !== 1'b0) begin
          n_fail++; $display("FAIL done_count: got %0d outputs valid=%b expected %0d valid=0", k, s_valid, npix);
        end
        if (exp_done >= 0) begin
          n_assert++;
          if (cyc != exp_done) begin
            n_fail++; $display("FAIL done_cycle: got %0d expected %0d", cyc, exp_done);
          end
        end
        break;
      end
    end
    if (got_done == 0) begin
      n_assert++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected %0d", cyc, exp_done);
    end
    if (exp_first >= 0) begin
      n_assert++;
      if (first_seen != exp_first) begin
        n_fail++; $display("FAIL first_valid: got %0d expected %0d", first_seen, exp_first);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_assert++;
    if ({a_busy, a_valid, a_done, b_busy, b_valid, b_done} !== 6'b0 ||
        a_data !== 8'sd0 || a_row !== 2'd0 || a_col !== 2'd0 ||
        b_data !== 8'sd0 || b_row !== 2'd0 || b_col !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b valid=%b done=%b data=%0d row=%0d col=%0d expected all 0",
               tag, a_busy, a_valid, a_done, a_data, a_row, a_col);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; start = 1'b0; ready = 1'b0;
    set_geom(0); fill(0, 0);
    #2 check_reset_outputs("reset_state");
    @(negedge clock); nreset = 1'b1;
    @(negedge clock); check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_ones();
    set_geom(0); fill(1, 1);
    run_frame(-1, 0, -1, 0, 10, 41);
    n_assert++;
    if (first_data !== 8'sd9) begin
      n_fail++; $display("FAIL ones_value: got %0d expected 9", first_data);
    end
  endtask

  task automatic test_stride();
    set_geom(1); fill(0, 0);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) m_img[r][c] = r;
    m_ker[1][1] = 1;
    load_dut();
    run_frame(-1, 0, -1, 0, 10, 91);
    n_assert++;
    if (first_data !== 8'sd1) begin
      n_fail++; $display("FAIL stride_value: got %0d expected 1", first_data);
    end
  endtask

  task automatic test_saturation();
    logic signed [7:0] want;
    set_geom(0); fill(127, 127);
    run_frame(-1, 0, -1, 0, 10, 41);
    n_assert++;
    if (first_data !== 8'sd127) begin
      n_fail++; $display("FAIL sat_pos: got %0d expected 127", first_data);
    end
    fill(-128, 127);
    run_frame(-1, 0, -1, 0, 10, 41);
`ifdef CONV2D_RELU_EN
    want = 8'sd0;
`else
    want = -8'sd128;
`endif
    n_assert++;
    if (first_data !== want) begin
      n_fail++; $display("FAIL sat_neg: got %0d expected %0d", first_data, want);
    end
  endtask

  task automatic test_backpressure();
    set_geom(0); fill(1, 1);
    m_img[1][2] = 5; m_img[2][1] = -3;
    load_dut();
    run_frame(1, 5, -1, 0, 10, 46);
  endtask

  task automatic test_abort();
    set_geom(0); fill(1, 1);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0; ready = 1'b1;
    for (int c = 0; c < 13; c++) @(negedge clock);
    nreset = 1'b0;
    #1 check_reset_outputs("abort_outputs");
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_assert++;
      if (a_done !== 1'b0 || a_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done: got done=%b valid=%b expected 0", a_done, a_valid);
      end
    end
    nreset = 1'b1;
    run_frame(-1, 0, -1, 0, 10, 41);
  endtask

  task automatic test_spurious_start();
    set_geom(0); fill(2, -1);
    m_img[0][0] = 40; m_img[3][3] = -7;
    load_dut();
    run_frame(-1, 0, 25, 0, 10, 41);
    run_frame(-1, 0, 41, 0, 10, 41);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      start = 1'b0;
      n_assert++;
      if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
        n_fail++; $display("FAIL start_on_done: got busy=%b valid=%b expected 0", a_busy, a_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_geom(1); fill(1, 1);
    run_frame(-1, 0, -1, 0, 10, 91);
    run_frame(-1, 0, -1, 0, 10, 91);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      set_geom(f % 2);
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++) m_img[r][c] = $urandom_range(0, 255) - 128;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) m_ker[r][c] = (f < 2) ? $urandom_range(0, 8) - 4 : $urandom_range(0, 255) - 128;
      load_dut();
      run_frame(-1, 0, -1, 1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_stride();
    test_saturation();
    test_backpressure();
    test_abort();
    test_spurious_start();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
